// File: rtl/div_seq_if.sv
// EX-stage <-> divider handshake: operands, request/flush and the result/status it returns.
interface div_seq_if #(
  parameter int WIDTH = 32
) ();
  logic                 signed_i;
  logic [WIDTH-1:0]     opdata1_i;
  logic [WIDTH-1:0]     opdata2_i;
  logic                 start_i;
  logic                 annul_i;
  logic [2*WIDTH-1:0]   result_o;
  logic                 ready_o;
  logic                 busy_o;

  modport master (
    output signed_i, opdata1_i, opdata2_i, start_i, annul_i,
    input  result_o, ready_o, busy_o
  );

  modport slave (
    input  signed_i, opdata1_i, opdata2_i, start_i, annul_i,
    output result_o, ready_o, busy_o
  );
endinterface

// File: rtl/div_seq.sv
// Sequential radix-2 restoring divider (DIV/DIVU) with IDLE/BYZERO/RUN/DONE sequencing.
// Optional DIV_EARLY_OUT_EN: finish immediately when |dividend| < |divisor|.
module div_seq #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input  logic      clk,
  input  logic      rst,
  div_seq_if.slave  bus
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_BYZERO = 2'd1,
    S_RUN    = 2'd2,
    S_DONE   = 2'd3
  } state_e;

  state_e               state_q, state_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [WIDTH-1:0]     rem_q, rem_d;
  logic [WIDTH-1:0]     quo_q, quo_d;
  logic [WIDTH-1:0]     absb_q, absb_d;
  logic                 neg_quo_q, neg_quo_d;
  logic                 neg_rem_q, neg_rem_d;
  logic [2*WIDTH-1:0]   result_q, result_d;
  logic                 ready_q, ready_d;
  logic                 busy_q, busy_d;

  logic                 accept_s;
  logic                 div_zero_s;
  logic                 early_s;
  logic                 last_s;
  logic [WIDTH-1:0]     abs_a_s, abs_b_s;
  logic [WIDTH:0]       rem_shift_s;
  logic                 ge_s;
  logic [WIDTH-1:0]     rem_step_s, quo_step_s;
  logic [WIDTH-1:0]     rem_fix_s, quo_fix_s;

  assign accept_s   = bus.start_i & ~bus.annul_i;
  assign div_zero_s = (bus.opdata2_i == {WIDTH{1'b0}});
  assign abs_a_s    = (bus.signed_i & bus.opdata1_i[WIDTH-1]) ? -bus.opdata1_i : bus.opdata1_i;
  assign abs_b_s    = (bus.signed_i & bus.opdata2_i[WIDTH-1]) ? -bus.opdata2_i : bus.opdata2_i;

`ifdef DIV_EARLY_OUT_EN
  assign early_s = (abs_a_s < abs_b_s);
`else
  assign early_s = 1'b0;
`endif

  // One restoring step: the partial remainder needs one extra bit before the compare.
  assign rem_shift_s = {rem_q, quo_q[WIDTH-1]};
  assign ge_s        = (rem_shift_s >= {1'b0, absb_q});
  assign rem_step_s  = ge_s ? (rem_shift_s[WIDTH-1:0] - absb_q) : rem_shift_s[WIDTH-1:0];
  assign quo_step_s  = {quo_q[WIDTH-2:0], ge_s};
  assign rem_fix_s   = neg_rem_q ? -rem_step_s : rem_step_s;
  assign quo_fix_s   = neg_quo_q ? -quo_step_s : quo_step_s;
  assign last_s      = (cnt_q == CNT_W'(WIDTH - 1));

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic; annul_i wins over start_i everywhere.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (accept_s) begin
          if (div_zero_s) begin
            state_d = S_BYZERO;
          end else if (early_s) begin
            state_d = S_DONE;
          end else begin
            state_d = S_RUN;
          end
        end else begin
          state_d = S_IDLE;
        end
      end
      S_BYZERO: state_d = bus.annul_i ? S_IDLE : S_DONE;
      S_RUN: begin
        if (bus.annul_i) begin
          state_d = S_IDLE;
        end else if (last_s) begin
          state_d = S_DONE;
        end else begin
          state_d = S_RUN;
        end
      end
      S_DONE: begin
        if (bus.annul_i) begin
          state_d = S_IDLE;
        end else if (bus.start_i) begin
          state_d = S_DONE;
        end else begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Datapath: latch magnitudes and sign flags on accept, iterate while running.
  always_comb begin
    cnt_d     = cnt_q;
    rem_d     = rem_q;
    quo_d     = quo_q;
    absb_d    = absb_q;
    neg_quo_d = neg_quo_q;
    neg_rem_d = neg_rem_q;
    case (state_q)
      S_IDLE: begin
        if (accept_s && !div_zero_s) begin
          cnt_d     = {CNT_W{1'b0}};
          rem_d     = {WIDTH{1'b0}};
          quo_d     = abs_a_s;
          absb_d    = abs_b_s;
          neg_quo_d = bus.signed_i & (bus.opdata1_i[WIDTH-1] ^ bus.opdata2_i[WIDTH-1]);
          neg_rem_d = bus.signed_i & bus.opdata1_i[WIDTH-1];
        end else begin
          cnt_d = cnt_q;
        end
      end
      S_RUN: begin
        if (!bus.annul_i) begin
          cnt_d = cnt_q + CNT_W'(1);
          rem_d = rem_step_s;
          quo_d = quo_step_s;
        end else begin
          cnt_d = cnt_q;
        end
      end
      default: cnt_d = cnt_q;
    endcase
  end

  // Output logic: result_o only changes on a transition into DONE.
  always_comb begin
    result_d = result_q;
    ready_d  = (state_d == S_DONE);
    busy_d   = (state_d == S_BYZERO) || (state_d == S_RUN);
    case (state_q)
      S_IDLE: begin
        if (state_d == S_DONE) begin
          result_d = {bus.opdata1_i, {WIDTH{1'b0}}};
        end else begin
          result_d = result_q;
        end
      end
      S_BYZERO: begin
        if (state_d == S_DONE) begin
          result_d = {2*WIDTH{1'b0}};
        end else begin
          result_d = result_q;
        end
      end
      S_RUN: begin
        if (state_d == S_DONE) begin
          result_d = {rem_fix_s, quo_fix_s};
        end else begin
          result_d = result_q;
        end
      end
      default: result_d = result_q;
    endcase
  end

  // Datapath and output registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q     <= {CNT_W{1'b0}};
      rem_q     <= {WIDTH{1'b0}};
      quo_q     <= {WIDTH{1'b0}};
      absb_q    <= {WIDTH{1'b0}};
      neg_quo_q <= 1'b0;
      neg_rem_q <= 1'b0;
      result_q  <= {2*WIDTH{1'b0}};
      ready_q   <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      rem_q     <= rem_d;
      quo_q     <= quo_d;
      absb_q    <= absb_d;
      neg_quo_q <= neg_quo_d;
      neg_rem_q <= neg_rem_d;
      result_q  <= result_d;
      ready_q   <= ready_d;
      busy_q    <= busy_d;
    end
  end

  assign bus.result_o = result_q;
  assign bus.ready_o  = ready_q;
  assign bus.busy_o   = busy_q;

endmodule

// File: tb/tb_div_seq.sv
// Self-checking bench for div_seq: directed table, hand-written annul/reset sequences, random vs. model.
module tb_div_seq;

  logic clk = 1'b0;
  logic rst;
  int   n_checks = 0;
  int   n_fail   = 0;

  div_seq_if #(.WIDTH(32)) bus ();

  div_seq #(.WIDTH(32), .CNT_W(6)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        sgn;
    logic [31:0] a;
    logic [31:0] b;
    logic [63:0] exp;
    int          hold;
  } vec_t;

  vec_t vecs[9];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference: magnitudes divided with 64-bit arithmetic, signs applied afterwards.
  function automatic logic [63:0] ref_div(input logic sgn, input logic [31:0] a, input logic [31:0] b);
    longint sa, sb, ma, mb, q, r;
    if (b == 32'd0) return 64'd0;
    sa = sgn ? longint'($signed(a)) : longint'({32'd0, a});
    sb = sgn ? longint'($signed(b)) : longint'({32'd0, b});
    ma = (sa < 0) ? -sa : sa;
    mb = (sb < 0) ? -sb : sb;
    q  = ma / mb;
    r  = ma % mb;
    if ((sa < 0) != (sb < 0)) q = -q;
    if (sa < 0) r = -r;
    return {r[31:0], q[31:0]};
  endfunction

  function automatic int ref_lat(input logic sgn, input logic [31:0] a, input logic [31:0] b);
    longint sa, sb, ma, mb;
    sa = sgn ? longint'($signed(a)) : longint'({32'd0, a});
    sb = sgn ? longint'($signed(b)) : longint'({32'd0, b});
    ma = (sa < 0) ? -sa : sa;
    mb = (sb < 0) ? -sb : sb;
    if (b == 32'd0) return 2;
`ifdef DIV_EARLY_OUT_EN
    if (ma < mb) return 1;
`endif
    return 33;
  endfunction

  task automatic do_div(input string name, input logic sgn, input logic [31:0] a,
                        input logic [31:0] b, input logic [63:0] exp, input int hold);
    int   edges;
    int   busy_cnt;
    int   lat;
    logic got;
    lat = ref_lat(sgn, a, b);
    @(negedge clk);
    bus.signed_i  = sgn;
    bus.opdata1_i = a;
    bus.opdata2_i = b;
    bus.start_i   = 1'b1;
    edges    = 0;
    busy_cnt = 0;
    got      = 1'b0;
    while (!got && edges < 100) begin
      @(posedge clk);
      #1;
      edges++;
      if (bus.busy_o === 1'b1) busy_cnt++;
      if (bus.ready_o === 1'b1) got = 1'b1;
      if (edges == 1) begin
        bus.signed_i  = ~sgn;
        bus.opdata1_i = ~a;
        bus.opdata2_i = $urandom;
      end
    end
    chk({name, " ready"},   64'(got), 64'd1);
    chk({name, " latency"}, 64'(edges), 64'(lat));
    chk({name, " busy"},    64'(busy_cnt), 64'(lat - 1));
    chk({name, " result"},  bus.result_o, exp);
    for (int k = 0; k < hold; k++) begin
      @(posedge clk);
      #1;
      chk({name, " ready held"}, 64'(bus.ready_o), 64'd1);
    end
    @(negedge clk);
    bus.start_i = 1'b0;
    @(posedge clk);
    #1;
    chk({name, " ready drop"}, 64'(bus.ready_o), 64'd0);
    chk({name, " result kept"}, bus.result_o, exp);
  endtask

  initial begin
    logic        sgn;
    logic [31:0] a, b;
    logic [63:0] prev;

    vecs[0] = '{1'b0, 32'd100,        32'd7,        {32'd2,        32'd14},        0};
    vecs[1] = '{1'b1, 32'hFFFF_FFF9,  32'd2,        {32'hFFFF_FFFF, 32'hFFFF_FFFD}, 0};
    vecs[2] = '{1'b0, 32'd5,          32'd0,        64'd0,                          0};
    vecs[3] = '{1'b1, 32'h8000_0000,  32'hFFFF_FFFF, {32'd0,        32'h8000_0000}, 3};
    vecs[4] = '{1'b1, 32'd7,          32'hFFFF_FFFE, {32'd1,        32'hFFFF_FFFD}, 0};
    vecs[5] = '{1'b1, 32'hFFFF_FFF9,  32'hFFFF_FFFE, {32'hFFFF_FFFF, 32'd3},        0};
    vecs[6] = '{1'b0, 32'hFFFF_FFFF,  32'd1,        {32'd0,        32'hFFFF_FFFF}, 0};
    vecs[7] = '{1'b0, 32'd3,          32'd10,       {32'd3,        32'd0},         0};
    vecs[8] = '{1'b1, 32'hFFFF_FFFD,  32'd10,       {32'hFFFF_FFFD, 32'd0},        0};

    rst           = 1'b1;
    bus.signed_i  = 1'b0;
    bus.opdata1_i = 32'd0;
    bus.opdata2_i = 32'd0;
    bus.start_i   = 1'b0;
    bus.annul_i   = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset result", bus.result_o, 64'd0);
    chk("reset ready",  64'(bus.ready_o), 64'd0);
    chk("reset busy",   64'(bus.busy_o), 64'd0);
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < 9; i++) begin
      do_div($sformatf("vec%0d", i), vecs[i].sgn, vecs[i].a, vecs[i].b, vecs[i].exp, vecs[i].hold);
    end
    prev = vecs[8].exp;

    // Flush after ten RUN iterations: nothing completes, result_o keeps the old value.
    @(negedge clk);
    bus.signed_i  = 1'b0;
    bus.opdata1_i = 32'd1000;
    bus.opdata2_i = 32'd3;
    bus.start_i   = 1'b1;
    repeat (11) @(posedge clk);
    #1;
    chk("annul pre busy", 64'(bus.busy_o), 64'd1);
    @(negedge clk);
    bus.annul_i = 1'b1;
    bus.start_i = 1'b0;
    @(posedge clk);
    #1;
    chk("annul busy",   64'(bus.busy_o), 64'd0);
    chk("annul ready",  64'(bus.ready_o), 64'd0);
    chk("annul result", bus.result_o, prev);
    @(negedge clk);
    bus.annul_i = 1'b0;
    repeat (40) @(posedge clk);
    #1;
    chk("annul no late ready", 64'(bus.ready_o), 64'd0);
    do_div("div 9/3", 1'b0, 32'd9, 32'd3, {32'd0, 32'd3}, 0);

    // Flush while DONE with start_i still high, then annul blocks a new accept.
    @(negedge clk);
    bus.opdata1_i = 32'd5;
    bus.opdata2_i = 32'd0;
    bus.start_i   = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("done annul pre ready", 64'(bus.ready_o), 64'd1);
    @(negedge clk);
    bus.annul_i = 1'b1;
    @(posedge clk);
    #1;
    chk("done annul ready", 64'(bus.ready_o), 64'd0);
    @(posedge clk);
    #1;
    chk("annul blocks start", 64'(bus.busy_o), 64'd0);
    @(negedge clk);
    bus.annul_i = 1'b0;
    bus.start_i = 1'b0;

    // Asynchronous reset in the middle of RUN.
    @(negedge clk);
    bus.opdata1_i = 32'd100;
    bus.opdata2_i = 32'd7;
    bus.start_i   = 1'b1;
    repeat (5) @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    chk("async rst result", bus.result_o, 64'd0);
    chk("async rst ready",  64'(bus.ready_o), 64'd0);
    chk("async rst busy",   64'(bus.busy_o), 64'd0);
    @(negedge clk);
    rst         = 1'b0;
    bus.start_i = 1'b0;
    do_div("post rst 3/10", 1'b0, 32'd3, 32'd10, {32'd3, 32'd0}, 0);

    for (int i = 0; i < 24; i++) begin
      sgn = 1'($urandom_range(0, 1));
      a   = $urandom;
      case (i % 4)
        0:       b = $urandom_range(0, 15);
        1:       b = $urandom;
        2:       b = 32'hFFFF_FFF0 | $urandom_range(0, 15);
        default: b = $urandom >> $urandom_range(0, 31);
      endcase
      if (i == 5) b = 32'd0;
      if (i == 6) a = $urandom_range(0, 7);
      do_div($sformatf("rand%0d", i), sgn, a, b, ref_div(sgn, a, b), 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
